// File: rtl/qsys_pio_edge_in.sv
// qsys_pio_edge_in: Avalon-MM input PIO with per-bit synchroniser, optional
// debouncer, sticky edge capture and a maskable level interrupt.
// Register words: 0 DATA (RO), 1 IRQMASK (RW), 2 EDGECAP (RW1C), 3 reserved.
`timescale 1ns/1ps

module qsys_pio_edge_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] syncChain_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stableDly_q;
  logic [WIDTH-1:0] edgeHit;
  logic [WIDTH-1:0] irqMask_q;
  logic [WIDTH-1:0] irqMask_d;
  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [WIDTH-1:0] edgeClr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      readData_q;
  logic [31:0]      readData_d;
  logic             writeStrobe;
  logic             unused_wdata;

  // Bits of writedata above WIDTH have no register behind them.
  assign unused_wdata = ^writedata;
  assign wdata        = writedata[WIDTH-1:0];
  assign writeStrobe  = chipselect & ~write_n;

  // Metastability chain: stage 0 samples the pins, last stage feeds the logic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= '0;
      end
    end else begin
      syncChain_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= syncChain_q[s-1];
      end
    end
  end

  assign sync = syncChain_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit only changes after differing from its accepted value for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old value restarts.
    always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (sync[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      end
    end

    // Accepted value and per-bit stability counters.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        stable_q <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        stable_q <= stable_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign stable = stable_q;
  end else begin : g_no_debounce
    assign stable = sync;
  end

  // Edge qualification against last cycle's accepted value.
  always_comb begin
    edgeHit = '0;
    if (EDGE_MODE == 0) begin
      edgeHit = stable & ~stableDly_q;
    end else if (EDGE_MODE == 1) begin
      edgeHit = ~stable & stableDly_q;
    end else begin
      edgeHit = stable ^ stableDly_q;
    end
  end

  // Next state of the writable registers; a new edge beats a same-cycle clear.
  always_comb begin
    irqMask_d = irqMask_q;
    edgeClr   = '0;
    if (writeStrobe && (address == 2'd1)) begin
      irqMask_d = wdata;
    end
    if (writeStrobe && (address == 2'd2)) begin
      edgeClr = wdata;
    end
    edgeCap_d = (edgeCap_q & ~edgeClr) | edgeHit;
  end

  // Read mux, captured every cycle regardless of chipselect.
  always_comb begin
    readData_d = '0;
    case (address)
      2'd0:    readData_d[WIDTH-1:0] = stable;
      2'd1:    readData_d[WIDTH-1:0] = irqMask_q;
      2'd2:    readData_d[WIDTH-1:0] = edgeCap_q;
      default: readData_d = '0;
    endcase
  end

  // Register state: delayed value, mask, sticky flags and read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stableDly_q <= '0;
      irqMask_q   <= '0;
      edgeCap_q   <= '0;
      readData_q  <= '0;
    end else begin
      stableDly_q <= stable;
      irqMask_q   <= irqMask_d;
      edgeCap_q   <= edgeCap_d;
      readData_q  <= readData_d;
    end
  end

  assign readdata = readData_q;
  assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_qsys_pio_edge_in.sv
// Bench for qsys_pio_edge_in: four parameter variants share one bus and one
// input port; a behavioural model predicts readdata and irq for each.
`timescale 1ns/1ps

module tb_qsys_pio_edge_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [7:0]  inPort;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  always #5 clk = ~clk;

  // u0: plain rising; u1: debounced rising; u2: falling; u3: narrow, deep, any edge
  qsys_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(inPort), .irq(irq0));
  qsys_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(inPort), .irq(irq1));
  qsys_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(inPort), .irq(irq2));
  qsys_pio_edge_in #(.WIDTH(6), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_MODE(2)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd3), .in_port(inPort[5:0]), .irq(irq3));

  function automatic int pSync(input int k);
    return (k == 3) ? 3 : 2;
  endfunction

  function automatic int pDeb(input int k);
    case (k)
      1:       return 4;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int pMode(input int k);
    case (k)
      2:       return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] pMask(input int k);
    return (k == 3) ? 32'h3F : 32'hFF;
  endfunction

  function automatic logic [31:0] dutRd(input int k);
    case (k)
      0:       return rd0;
      1:       return rd1;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

  function automatic logic dutIrq(input int k);
    case (k)
      0:       return irq0;
      1:       return irq1;
      2:       return irq2;
      default: return irq3;
    endcase
  endfunction

  // Model state: sampled pin history (hist[0] newest) and per-variant registers
  logic [7:0]  hist [16];
  logic [31:0] mStable [4];
  logic [31:0] mStableDly [4];
  logic [31:0] mEdge [4];
  logic [31:0] mMask [4];
  logic [31:0] mRd [4];

  // Advance the model by one rising edge using the values present before it.
  task automatic modelStep();
    logic [31:0] wm, cur, edg, clr, acc, nRd, nStable;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        mStable[k] = '0; mStableDly[k] = '0; mEdge[k] = '0; mMask[k] = '0; mRd[k] = '0;
      end
      for (int j = 0; j < 16; j++) hist[j] = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        wm  = pMask(k);
        cur = (pDeb(k) == 0) ? ({24'b0, hist[pSync(k)-1]} & wm) : mStable[k];
        case (pMode(k))
          0:       edg = cur & ~mStableDly[k] & wm;
          1:       edg = ~cur & mStableDly[k] & wm;
          default: edg = (cur ^ mStableDly[k]) & wm;
        endcase
        clr = (chipselect && !write_n && address == 2'd2) ? (writedata & wm) : 32'h0;
        case (address)
          2'd0:    nRd = cur;
          2'd1:    nRd = mMask[k];
          2'd2:    nRd = mEdge[k];
          default: nRd = 32'h0;
        endcase
        // A bit is accepted once its last DEB synchronised samples all disagree
        nStable = mStable[k];
        if (pDeb(k) > 0) begin
          acc = wm;
          for (int j = 0; j < pDeb(k); j++) begin
            acc = acc & ({24'b0, hist[pSync(k)-1+j]} ^ mStable[k]);
          end
          nStable = mStable[k] ^ acc;
        end
        if (chipselect && !write_n && address == 2'd1) mMask[k] = writedata & wm;
        mEdge[k]      = (mEdge[k] & ~clr) | edg;
        mRd[k]        = nRd;
        mStableDly[k] = cur;
        mStable[k]    = nStable;
      end
      for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = inPort;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic [7:0] ip, input logic cs, input logic wrn,
                               input logic [1:0] addr, input logic [31:0] wd, input logic rstn);
    inPort     = ip;
    chipselect = cs;
    write_n    = wrn;
    address    = addr;
    writedata  = wd;
    reset_n    = rstn;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input logic [7:0] ip, input logic [1:0] addr, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ip, 1'b0, 1'b1, addr, 32'h0, 1'b1);
  endtask

  task automatic busWrite(input logic [7:0] ip, input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(ip, 1'b1, 1'b0, addr, wd, 1'b1);
  endtask

  // Compare every variant against the model on each falling edge.
  always @(negedge clk) begin
    if (chkEn) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("model_rd_u%0d", k), dutRd(k), mRd[k]);
        checkOutput($sformatf("model_irq_u%0d", k), {31'b0, dutIrq(k)}, {31'b0, |(mEdge[k] & mMask[k])});
      end
    end
  end

  initial begin
    logic [7:0] ip;
    int b;
    inPort = '0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; reset_n = 1'b0;

    // Reset held three cycles with pins low
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
      chkEn = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rst_rd_u%0d", k), dutRd(k), 32'h0);
      checkOutput($sformatf("rst_irq_u%0d", k), {31'b0, dutIrq(k)}, 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      applyStimulus(8'h00, 1'b0, 1'b1, 2'(a), 32'h0, 1'b1);
      checkOutput($sformatf("idle_rd_addr%0d", a), rd0 | rd1 | rd2 | rd3, 32'h0);
    end

    // Rising latency: u0 at 3, u3 at 3+2+1, u1 at 2+4+1, u2 never
    busWrite(8'h00, 2'd1, 32'h01);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(8'h01, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      checkOutput($sformatf("lat_u0_e%0d", i), {31'b0, irq0}, {31'b0, i >= 3});
      checkOutput($sformatf("lat_u1_e%0d", i), {31'b0, irq1}, {31'b0, i >= 7});
      checkOutput($sformatf("lat_u2_e%0d", i), {31'b0, irq2}, 32'h0);
      checkOutput($sformatf("lat_u3_e%0d", i), {31'b0, irq3}, {31'b0, i >= 6});
    end
    checkOutput("lat_u0_data", rd0, 32'h01);
    applyStimulus(8'h01, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
    checkOutput("lat_u0_edgecap", rd0, 32'h01);
    busWrite(8'h01, 2'd2, 32'h01);
    checkOutput("w1c_u0_irq", {31'b0, irq0}, 32'h0);

    // Three-cycle glitch on bit 2 is rejected by the debouncer
    for (int i = 0; i < 3; i++) applyStimulus(8'h05, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    idle(8'h01, 2'd0, 10);
    checkOutput("glitch_u1_data", rd1, 32'h01);
    applyStimulus(8'h01, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
    checkOutput("glitch_u1_edgecap", rd1, 32'h00);

    // Held high on bit 2: captured at edge 7
    busWrite(8'h01, 2'd2, 32'hFF);
    busWrite(8'h01, 2'd1, 32'h04);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'h05, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      checkOutput($sformatf("deb_u1_e%0d", i), {31'b0, irq1}, {31'b0, i >= 7});
    end

    // Clear on the same edge as a bit-7 capture: set wins
    idle(8'h05, 2'd0, 10);
    busWrite(8'h05, 2'd2, 32'hFF);
    applyStimulus(8'h85, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
    applyStimulus(8'h85, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
    applyStimulus(8'h85, 1'b1, 1'b0, 2'd2, 32'h80, 1'b1);
    applyStimulus(8'h85, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
    checkOutput("setwins_u0_bit7", rd0 & 32'h80, 32'h80);

    // Modes on bit 0: fall then rise
    idle(8'h85, 2'd0, 10);
    busWrite(8'h85, 2'd2, 32'hFF);
    busWrite(8'h85, 2'd1, 32'h01);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'h84, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      checkOutput($sformatf("fall_u0_e%0d", i), {31'b0, irq0}, 32'h0);
      checkOutput($sformatf("fall_u2_e%0d", i), {31'b0, irq2}, {31'b0, i >= 3});
      checkOutput($sformatf("fall_u3_e%0d", i), {31'b0, irq3}, {31'b0, i >= 6});
    end
    busWrite(8'h84, 2'd2, 32'h01);
    checkOutput("clr_u3_irq", {31'b0, irq3}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'h85, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      checkOutput($sformatf("rise_u0_e%0d", i), {31'b0, irq0}, {31'b0, i >= 3});
      checkOutput($sformatf("rise_u2_e%0d", i), {31'b0, irq2}, 32'h0);
      checkOutput($sformatf("rise_u3_e%0d", i), {31'b0, irq3}, {31'b0, i >= 6});
    end

    // Mask gating and mask write latency
    busWrite(8'h85, 2'd1, 32'h00);
    idle(8'h00, 2'd0, 8);
    idle(8'h10, 2'd0, 8);
    checkOutput("mask0_u3_irq", {31'b0, irq3}, 32'h0);
    busWrite(8'h10, 2'd1, 32'h10);
    checkOutput("mask10_u3_irq", {31'b0, irq3}, 32'h1);

    // Reserved word: writes ignored, reads zero
    busWrite(8'h10, 2'd3, 32'hFFFF_FFFF);
    applyStimulus(8'h10, 1'b0, 1'b1, 2'd1, 32'h0, 1'b1);
    checkOutput("rsvd_u0_mask", rd0, 32'h10);
    applyStimulus(8'h10, 1'b0, 1'b1, 2'd3, 32'h0, 1'b1);
    checkOutput("rsvd_u0_read", rd0, 32'h0);

    // Reset in the middle of a bit-3 debounce aborts it
    for (int i = 0; i < 3; i++) applyStimulus(8'h18, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    applyStimulus(8'h18, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    applyStimulus(8'h18, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    idle(8'h10, 2'd2, 14);
    checkOutput("rstabort_u1_edgecap", rd1, 32'h10);
    checkOutput("rstabort_u1_irq", {31'b0, irq1}, 32'h0);

    // Randomised traffic against the model
    ip = 8'h10;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(0, 7);
        ip[b] = ~ip[b];
      end
      applyStimulus(ip, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 249) != 0));
    end

    @(negedge clk);
    #1;
    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
